// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: four inverse S-box lanes substitute one 32-bit word
// of the buffered state per cycle, with valid/ready handshakes on both sides.
module inv_sub_bytes_iter #(
  parameter int BYTE   = 8,
  parameter int DWORD  = 32,
  parameter int LENGTH = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_data
);

  localparam int NWORD = LENGTH / DWORD;
  localparam int NLANE = DWORD / BYTE;
  localparam int CW    = (NWORD > 1) ? $clog2(NWORD) : 1;

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [LENGTH-1:0] buffer;
  logic              out_valid_r;
  logic [DWORD-1:0]  word_cur;
  logic [DWORD-1:0]  word_sub;

  assign word_cur = buffer[cnt*DWORD +: DWORD];

  genvar gi;
  generate
    for (gi = 0; gi < NLANE; gi++) begin : g_lane
      assign word_sub[gi*BYTE +: BYTE] = INV_SBOX[word_cur[gi*BYTE +: BYTE]];
    end
  endgenerate

  // DONE accepts a new block in the same cycle its result is taken.
  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = out_valid_r;
  assign out_data  = out_valid_r ? buffer : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      buffer      <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            buffer <= in_data;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          buffer[cnt*DWORD +: DWORD] <= word_sub;
          if (cnt == CW'(NWORD - 1)) begin
            cnt         <= '0;
            state       <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (in_valid) begin
              buffer <= in_data;
              cnt    <= '0;
              state  <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Scoreboard bench for inv_sub_bytes_iter: blocks are pre-substituted with a forward
// S-box computed from GF(2^8) arithmetic, so the expected output is the original block.
module tb_inv_sub_bytes_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  logic [127:0] exp_cur;
  logic [127:0] sb [$];
  logic [7:0]   fwd [256];
  int           n_cmp = 0;
  int           n_err = 0;
  int           n_blk = 0;

  inv_sub_bytes_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [127:0] fwd_block(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd[x[8*i +: 8]];
    return r;
  endfunction

  // Monitor: handshakes are decided at the next posedge by values stable at this negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        logic [127:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_blk++;
        $display("blk %0d out=%h", n_blk, out_data);
        check_val("block", out_data, e);
      end
      if (in_valid && in_ready) sb.push_back(exp_cur);
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] e);
    int n;
    in_data  = d;
    exp_cur  = e;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("accept", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 128'(sb.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_latency(input string tag);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val(tag, 128'(out_valid), (i == 4) ? 128'd1 : 128'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] orig;
    logic [127:0] orig_b;
    logic [7:0]   inv;
    int           n;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      fwd[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; exp_cur = '0;
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", 128'(out_valid), 128'd0);
    check_val("rst_out_data", out_data, 128'd0);
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: all-zero block, exact latency.
    in_data = '0; exp_cur = {16{8'h52}}; in_valid = 1'b1;
    @(negedge clk);
    check_val("idle_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    check_latency("latency");
    @(posedge clk); #1;

    // Test 2: known vector.
    send(128'h63636363_7C7C7C7C_EDEDEDED_16161616, 128'h00000000_01010101_53535353_FFFFFFFF);

    // Round trip: sweep every byte value, then random blocks back-to-back.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) orig[8*j +: 8] = 8'(i*16 + j);
      send(fwd_block(orig), orig);
    end
    for (int i = 0; i < 1000; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      send(fwd_block(orig), orig);
    end
    drain();

    // Test 4: backpressure with a new block waiting.
    out_ready = 1'b0;
    orig   = {$urandom, $urandom, $urandom, $urandom};
    orig_b = {$urandom, $urandom, $urandom, $urandom};
    send(fwd_block(orig), orig);
    in_data = fwd_block(orig_b); exp_cur = orig_b; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      check_val("bp_hold_data", out_data, orig);
      check_val("bp_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_accept", 128'(in_ready), 128'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    check_latency("bp_latency");
    drain();

    // Test 5: asynchronous reset in the middle of BUSY.
    orig = {$urandom, $urandom, $urandom, $urandom};
    send(fwd_block(orig), orig);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_val("rst_mid_out_valid", 128'(out_valid), 128'd0);
    @(posedge clk); #3; rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("post_rst_out_valid", 128'(out_valid), 128'd0);
      check_val("post_rst_in_ready", 128'(in_ready), 128'd1);
    end
    @(posedge clk); #1;
    orig = {$urandom, $urandom, $urandom, $urandom};
    send(fwd_block(orig), orig);
    drain();

    // Test 6: input toggling while BUSY is ignored.
    orig = {$urandom, $urandom, $urandom, $urandom};
    in_data = fwd_block(orig); exp_cur = orig; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      exp_cur = ~orig;
      @(negedge clk);
      check_val("busy_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
